// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM update scheduler.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } pwm_state_e;

  localparam int COMPARE_SIZE_DEF = 8;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_rr_arbiter.sv
// Round-robin pick: first eligible (req & ~mask) index at or above ptr, wrapping.
module pwm_rr_arbiter
  import pwm_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [NUM_REQ-1:0] mask_in,
  input  logic [PTR_W-1:0]   ptr_in,
  output logic [NUM_REQ-1:0] gnt_out,
  output logic               vld_out
);

  logic [NUM_REQ-1:0] elig;

  // Scan from the pointer upward and stop at the first eligible requester.
  always_comb begin
    int idx;
    elig    = req_in & ~mask_in;
    gnt_out = '0;
    vld_out = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_in) + k) % NUM_REQ;
      if (!vld_out && elig[idx]) begin
        gnt_out[idx] = 1'b1;
        vld_out      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_update_scheduler.sv
// Serialises (channel, compare) updates from several requesters onto a shared
// compare bus with a setup / hold-high / hold-low write strobe per channel.
module pwm_update_scheduler
  import pwm_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CH       = 4,
  parameter int COMPARE_SIZE = COMPARE_SIZE_DEF,
  parameter int WR_HOLD      = 2,
  parameter int WR_GAP       = 2,
  parameter int CH_W         = clog2_min1(NUM_CH)
) (
  input  logic                            clk_in,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*CH_W-1:0]         req_ch,
  input  logic [NUM_REQ*COMPARE_SIZE-1:0] req_compare,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            err,
  output logic                            busy,
  output logic [COMPARE_SIZE-1:0]         compare_out,
  output logic [NUM_CH-1:0]               wr_out
);

  localparam int PTR_W   = clog2_min1(NUM_REQ);
  localparam int CNT_MAX = (WR_HOLD > WR_GAP) ? WR_HOLD : WR_GAP;
  localparam int CNT_W   = clog2_min1(CNT_MAX);

  pwm_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]      mask_q, mask_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [COMPARE_SIZE-1:0] compare_out_q, compare_out_d;
  logic [NUM_CH-1:0]       wr_out_q, wr_out_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic                    arb_vld;
  int                      arb_idx;
  logic                    last_rec;

  pwm_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_in  (req),
    .mask_in (mask_q),
    .ptr_in  (ptr_q),
    .gnt_out (arb_gnt),
    .vld_out (arb_vld)
  );

  // Binary index of the arbiter's one-hot grant, for data selection.
  always_comb begin
    arb_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = i;
    end
  end

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ptr_q         <= '0;
      mask_q        <= '0;
      gnt_q         <= '0;
      ch_q          <= '0;
      compare_out_q <= '0;
      wr_out_q      <= '0;
      ack_q         <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      mask_q        <= mask_d;
      gnt_q         <= gnt_d;
      ch_q          <= ch_d;
      compare_out_q <= compare_out_d;
      wr_out_q      <= wr_out_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
    end
  end

  // Next state: grant in IDLE, then sequence SETUP / STROBE / RECOVER.
  // The requester acked this cycle is masked for exactly the next cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    ch_d          = ch_q;
    compare_out_d = compare_out_q;
    mask_d        = ack_q;
    case (state_q)
      IDLE: begin
        if (ena && arb_vld) begin
          state_d       = SETUP;
          gnt_d         = arb_gnt;
          ch_d          = req_ch[arb_idx*CH_W +: CH_W];
          compare_out_d = req_compare[arb_idx*COMPARE_SIZE +: COMPARE_SIZE];
          ptr_d         = PTR_W'((arb_idx + 1) % NUM_REQ);
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: begin
        if (cnt_q == CNT_W'(WR_HOLD - 1)) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: begin
        if (cnt_q == CNT_W'(WR_GAP - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs registered from the next state so each reflects its own cycle.
  // An out-of-range channel matches no wr_out bit, so the strobe stays low.
  always_comb begin
    busy_d   = (state_d != IDLE);
    wr_out_d = '0;
    if (state_d == STROBE) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_out_d[c] = (int'(ch_d) == c);
      end
    end
    last_rec = (state_d == RECOVER) && (cnt_d == CNT_W'(WR_GAP - 1));
    ack_d    = last_rec ? gnt_d : '0;
    err_d    = last_rec && (int'(ch_d) >= NUM_CH);
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign compare_out = compare_out_q;
  assign wr_out      = wr_out_q;

endmodule

// File: doc/pwm_update_scheduler.md
# pwm_update_scheduler

Serialises duty-cycle updates from several requesters onto a bank of PWM channel generators that share one compare bus. Requesters post (channel, compare) pairs with a req/ack handshake. The scheduler picks one requester round-robin, drives the shared compare bus, and issues a timed write strobe to the selected channel. The strobe is a setup, hold-high, hold-low sequence, so each generator latches exactly one value per strobe. It sits between the register/control front end and the PWM generator bank.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- NUM_CH, 4, number of PWM channels driven (≥1)
- COMPARE_SIZE, 8, compare value width
- WR_HOLD, 2, cycles wr stays high (≥1; must cover one generator-clock period)
- WR_GAP, 2, cycles wr stays low after strobe before ack (≥1)
- CH_W, $clog2(NUM_CH) (min 1), derived channel-index width

Ports:
- clk_in  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  grant enable; low blocks new grants only
- req  in  NUM_REQ  per-requester request, held until ack
- req_ch  in  NUM_REQ*CH_W  packed target channel per requester
- req_compare  in  NUM_REQ*COMPARE_SIZE  packed compare value per requester
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse
- err  out  1  one-cycle pulse with ack when the target channel is ≥ NUM_CH
- busy  out  1  high whenever state ≠ IDLE
- compare_out  out  COMPARE_SIZE  shared compare bus to the generators
- wr_out  out  NUM_CH  per-channel write strobe

## Operation
- Reset values: ack=0, err=0, busy=0, compare_out=0, wr_out=0, state=IDLE, rr pointer=0, mask=0.
- States:
  - IDLE → SETUP when ena=1 and any eligible req. Grant the first eligible index at or above the pointer, wrapping. Pointer ← grant+1 mod NUM_REQ.
  - SETUP, 1 cycle: compare_out ← granted value, wr_out all low, channel latched.
  - SETUP → STROBE for WR_HOLD cycles: wr_out[ch]=1, other bits 0.
  - STROBE → RECOVER for WR_GAP cycles: wr_out=0.
  - RECOVER → IDLE after its last cycle.
- ack[grant]=1 during the last RECOVER cycle.
- Invalid channel (≥ NUM_CH): the sequence still runs with wr_out held 0; err=1 together with ack.
- Requester data (req_ch, req_compare) is captured once at grant. Later changes are ignored until the next grant.
- compare_out retains the last written value in IDLE; it is never cleared except by reset.
- Re-grant guard: the requester just acked is masked for the first IDLE cycle, because its req is still high in that cycle. The mask clears after one cycle.
- ena=0 mid-transaction: the transaction completes normally, including ack. No new grant while ena=0.
- req dropped before ack is a protocol violation. The scheduler completes the write and pulses ack anyway.
- Reset mid-transaction:
  - Next cycle all outputs return to reset values, including wr_out=0.
  - The aborted request gets no ack.
  - Pointer returns to 0.

## Timing
- Latency, with IDLE sampling req in cycle 0:
  - SETUP in cycle 1.
  - wr high in cycles 2 … 1+WR_HOLD.
  - ack in cycle 1+WR_HOLD+WR_GAP; defaults give cycles 2–3 and ack at cycle 5.
- Back-to-back throughput: next SETUP no earlier than 2 cycles after ack (IDLE, then SETUP). One write per WR_HOLD+WR_GAP+2 cycles.
- compare_out is stable from SETUP through the end of RECOVER; it never changes while any wr_out bit is high.
- All outputs are registered; none depends combinationally on req.

## Structure
- Shared package pwm_pkg holds:
  - the state enum typedef (IDLE, SETUP, STROBE, RECOVER);
  - the default COMPARE_SIZE constant;
  - a clog2-with-minimum-1 width function used for CH_W.
- Sub-module pwm_rr_arbiter:
  - inputs: NUM_REQ-wide request vector, mask, pointer;
  - outputs: one-hot grant plus a valid bit;
  - purely combinational.
- Pointer, mask and hold/gap counters stay in the top level.
- Counter widths are sized from max(WR_HOLD, WR_GAP).

## Test plan
- Single write: req[1]=1, ch=2, compare=0x80 → compare_out=0x80 at cycle 1; wr_out=4'b0100 at cycles 2–3; ack=4'b0010 at cycle 5; err=0.
- Contention: req=4'b1111 held and dropped on ack → grants in order 0,1,2,3; each ack one cycle, 6 cycles apart; no wr_out overlap.
- Hog guard: req[0] held high through its ack, dropped one cycle later → exactly one write, one ack.
- Invalid channel (NUM_CH=3, ch=3, compare=0x55) → wr_out stays 0; ack and err pulse together at cycle 5.
- ena gating: ena low during STROBE with req[2] also pending → current ack occurs; req[2] is not granted until ena returns high.
- Reset in STROBE → wr_out=0, busy=0, compare_out=0 next cycle; no ack; next grant starts from index 0.
